frame_sync_ctrl: RTL and testbench

Frame-synchronisation controller for the serial bit-stream path. It hunts a serial input for a parameterised sync word and confirms the word at the expected frame period before declaring lock. While locked it checks every frame boundary and flywheels through isolated misses. It sits after the bit-stream front end and drives `locked`, `frame_start` and `bit_idx` to the downstream deframer.

---
 rtl/frame_sync_ctrl.sv | 157 +++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_ctrl.sv
// Serial frame-sync hunter with confirm, lock and flywheel states.
// Optional loss counter output under FRAME_SYNC_LOSS_CNT_EN.
module frame_sync_ctrl #(
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1001,
  parameter int                FRAME_LEN = 16,
  parameter int                LOCK_CNT  = 3,
  parameter int                MISS_CNT  = 2,
  localparam int               BW = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          din_valid,
  input  logic          din,
  input  logic          hunt_restart,
  output logic [1:0]    state,
  output logic          locked,
  output logic          frame_start,
  output logic          sync_err,
  output logic [BW-1:0] bit_idx
`ifdef FRAME_SYNC_LOSS_CNT_EN
  ,
  output logic [7:0]    loss_cnt
`endif
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);
  localparam int FW = $clog2(SYNC_W);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    CONFIRM  = 2'd1,
    LOCKED   = 2'd2,
    FLYWHEEL = 2'd3
  } state_t;

  state_t            st, st_nx;
  logic [SYNC_W-2:0] hist, hist_nx;
  logic [FW-1:0]     fill, fill_nx;
  logic [CW-1:0]     conf, conf_nx;
  logic [MW-1:0]     miss, miss_nx;
  logic [BW-1:0]     idx_nx;
  logic              fs_nx, se_nx;
  logic              acc, match, bnd;
  logic [SYNC_W-1:0] word;

  assign acc   = enable & din_valid;
  assign word  = {hist, din};
  assign match = (fill == FW'(SYNC_W - 1)) && (word == SYNC_WORD);
  assign bnd   = (bit_idx == BW'(FRAME_LEN - 1));
  assign state = st;

  always_comb begin
    st_nx   = st;
    hist_nx = hist;
    fill_nx = fill;
    conf_nx = conf;
    miss_nx = miss;
    idx_nx  = bit_idx;
    fs_nx   = 1'b0;
    se_nx   = 1'b0;
    if (hunt_restart) begin
      st_nx   = HUNT;
      hist_nx = '0;
      fill_nx = '0;
      conf_nx = '0;
      miss_nx = '0;
      idx_nx  = '0;
    end else if (acc) begin
      hist_nx = word[SYNC_W-2:0];
      if (fill != FW'(SYNC_W - 1))
        fill_nx = fill + FW'(1);
      idx_nx = bnd ? '0 : bit_idx + BW'(1);
      unique case (st)
        HUNT: begin
          idx_nx = '0;
          if (match) begin
            conf_nx = CW'(1);
            st_nx   = CONFIRM;
          end
        end
        CONFIRM: begin
          if (bnd && match) begin
            conf_nx = conf + CW'(1);
            if (conf_nx == CW'(LOCK_CNT))
              st_nx = LOCKED;
          end else if (bnd) begin
            conf_nx = '0;
            st_nx   = HUNT;
          end
        end
        LOCKED, FLYWHEEL: begin
          if (bnd && match) begin
            miss_nx = '0;
            fs_nx   = 1'b1;
            st_nx   = LOCKED;
          end else if (bnd) begin
            se_nx   = 1'b1;
            miss_nx = miss + MW'(1);
            st_nx   = FLYWHEEL;
            if (miss_nx == MW'(MISS_CNT)) begin
              miss_nx = '0;
              conf_nx = '0;
              st_nx   = HUNT;
            end
          end
        end
        default: st_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= HUNT;
      hist        <= '0;
      fill        <= '0;
      conf        <= '0;
      miss        <= '0;
      bit_idx     <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      st          <= st_nx;
      hist        <= hist_nx;
      fill        <= fill_nx;
      conf        <= conf_nx;
      miss        <= miss_nx;
      bit_idx     <= idx_nx;
      locked      <= (st_nx == LOCKED) || (st_nx == FLYWHEEL);
      frame_start <= fs_nx;
      sync_err    <= se_nx;
    end
  end

`ifdef FRAME_SYNC_LOSS_CNT_EN
  logic lost;

  // Only losses out of lock count; CONFIRM falling back is a failed hunt.
  assign lost = acc & ~hunt_restart
              & ((st == LOCKED) || (st == FLYWHEEL))
              & (st_nx == HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      loss_cnt <= '0;
    else if (hunt_restart)
      loss_cnt <= '0;
    else if (lost && loss_cnt != 8'hff)
      loss_cnt <= loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl at default parameters.
// Expected values are hand-derived from the bit stream.
module tb_frame_sync_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       din_valid;
  logic       din;
  logic       hunt_restart;
  logic [1:0] state;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
  logic [3:0] bit_idx;
`ifdef FRAME_SYNC_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  frame_sync_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .din_valid    (din_valid),
    .din          (din),
    .hunt_restart (hunt_restart),
    .state        (state),
    .locked       (locked),
    .frame_start  (frame_start),
    .sync_err     (sync_err),
    .bit_idx      (bit_idx)
`ifdef FRAME_SYNC_LOSS_CNT_EN
    ,
    .loss_cnt     (loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    enable    = 1'b1;
    din_valid = 1'b1;
    din       = b;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--)
      send_bit(w[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++)
      send_bit(1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    din_valid    = 1'b0;
    din          = 1'b0;
    hunt_restart = 1'b0;

    // reset with random stimulus
    for (int i = 0; i < 4; i++) begin
      din       = 1'($urandom);
      din_valid = 1'($urandom);
      tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_fs", 32'(frame_start), 0);
      chk("rst_se", 32'(sync_err), 0);
      chk("rst_idx", 32'(bit_idx), 0);
    end
    din_valid = 1'b0;
    rst_n     = 1'b1;
    tick();

    // acquisition
    send_zeros(4);
    chk("pre_state", 32'(state), 0);
    send_word(4'b1001);
    chk("hit1_state", 32'(state), 1);
    chk("hit1_idx", 32'(bit_idx), 0);
    chk("hit1_locked", 32'(locked), 0);
    send_zeros(12);
    chk("conf_idx12", 32'(bit_idx), 12);
    send_word(4'b1001);
    chk("hit2_state", 32'(state), 1);
    chk("hit2_idx", 32'(bit_idx), 0);
    send_zeros(12);
    send_word(4'b1001);
    chk("hit3_state", 32'(state), 2);
    chk("hit3_locked", 32'(locked), 1);
    chk("hit3_idx", 32'(bit_idx), 0);
    chk("hit3_fs", 32'(frame_start), 0);
    send_zeros(12);
    send_word(4'b1001);
    chk("lk_fs", 32'(frame_start), 1);
    chk("lk_state", 32'(state), 2);
    chk("lk_idx", 32'(bit_idx), 0);
    chk("lk_se", 32'(sync_err), 0);
    send_zeros(1);
    chk("lk_fs_clr", 32'(frame_start), 0);
    chk("lk_idx1", 32'(bit_idx), 1);
    send_zeros(11);

    // single corrupted sync word
    send_word(4'b1011);
    chk("miss1_se", 32'(sync_err), 1);
    chk("miss1_state", 32'(state), 3);
    chk("miss1_locked", 32'(locked), 1);
    chk("miss1_fs", 32'(frame_start), 0);
    send_zeros(12);
    send_word(4'b1001);
    chk("rec_state", 32'(state), 2);
    chk("rec_fs", 32'(frame_start), 1);
    chk("rec_se", 32'(sync_err), 0);
    send_zeros(1);
    chk("rec_se_clr", 32'(sync_err), 0);
    send_zeros(11);

    // two consecutive corrupted sync words
    send_word(4'b1011);
    chk("lossA_state", 32'(state), 3);
    chk("lossA_se", 32'(sync_err), 1);
    send_zeros(12);
    send_word(4'b1011);
    chk("lossB_state", 32'(state), 0);
    chk("lossB_locked", 32'(locked), 0);
    chk("lossB_se", 32'(sync_err), 1);
    chk("lossB_idx", 32'(bit_idx), 0);
`ifdef FRAME_SYNC_LOSS_CNT_EN
    chk("loss_cnt1", 32'(loss_cnt), 1);
`endif

    // lone sync word then a missed boundary
    send_zeros(4);
    send_word(4'b1001);
    chk("lone_state", 32'(state), 1);
    send_zeros(15);
    chk("lone_idx15", 32'(bit_idx), 15);
    chk("lone_st_c", 32'(state), 1);
    send_zeros(1);
    chk("lone_hunt", 32'(state), 0);
    chk("lone_locked", 32'(locked), 0);
`ifdef FRAME_SYNC_LOSS_CNT_EN
    chk("loss_cnt_conf", 32'(loss_cnt), 1);
`endif

    // relock, then valid gaps and enable freeze
    send_word(4'b1001);
    send_zeros(12);
    send_word(4'b1001);
    send_zeros(12);
    send_word(4'b1001);
    chk("relock_state", 32'(state), 2);
    send_zeros(5);
    chk("gap_pre_idx", 32'(bit_idx), 5);
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b0;
      din       = 1'b1;
      tick();
    end
    chk("gap_idx", 32'(bit_idx), 5);
    chk("gap_state", 32'(state), 2);
    for (int i = 0; i < 3; i++) begin
      enable    = 1'b0;
      din_valid = 1'b1;
      din       = 1'b1;
      tick();
    end
    enable    = 1'b1;
    din_valid = 1'b0;
    chk("en_idx", 32'(bit_idx), 5);
    chk("en_locked", 32'(locked), 1);
    send_zeros(7);
    send_word(4'b1001);
    chk("gap_fs", 32'(frame_start), 1);
    chk("gap_state2", 32'(state), 2);

    // restart with a simultaneous valid bit
    hunt_restart = 1'b1;
    send_bit(1'b1);
    hunt_restart = 1'b0;
    chk("rs_state", 32'(state), 0);
    chk("rs_idx", 32'(bit_idx), 0);
    chk("rs_locked", 32'(locked), 0);
    chk("rs_fs", 32'(frame_start), 0);
`ifdef FRAME_SYNC_LOSS_CNT_EN
    chk("rs_loss", 32'(loss_cnt), 0);
`endif
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("rs_discard", 32'(state), 0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("rs_rehunt", 32'(state), 1);

    // reset mid-frame
    send_zeros(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_state", 32'(state), 0);
    chk("mrst_idx", 32'(bit_idx), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_word(4'b1001);
    chk("mrst_hit", 32'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
